// File: rtl/alu_issue_pkg.sv
// Shared codes and types for the ALU issue stage.
// Holds decode encodings, FSM states and the result-buffer entry.
package alu_issue_pkg;

   localparam logic [1:0] AOP_ADD = 2'b00;
   localparam logic [1:0] AOP_SUB = 2'b01;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] F_AND = 3'b000;
   localparam logic [2:0] F_OR  = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b110;
   localparam logic [2:0] F_SLT = 3'b111;

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_t;

   typedef struct packed {
      logic [31:0] y;
      logic        z;
      logic        ill;
   } rb_entry_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from aluop/funct.
// Unknown R-type functs fall back to AND and are flagged.
module alu_decoder
   import alu_issue_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] f,
   output logic       illegal
);

   always_comb begin
      f       = F_AND;
      illegal = 1'b0;
      unique case (1'b1)
         (aluop == AOP_ADD): f = F_ADD;
         (aluop == AOP_SUB): f = F_SUB;
         default: begin
            case (funct)
               FN_ADD:  f = F_ADD;
               FN_SUB:  f = F_SUB;
               FN_AND:  f = F_AND;
               FN_OR:   f = F_OR;
               FN_SLT:  f = F_SLT;
               default: illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: registers operands for an external ALU and
// captures its result into a 2-entry in-order result buffer.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  aluop,
   input  logic [5:0]  funct,
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        illegal,
   output logic [15:0] op_count
);

   state_t    state, nstate;
   rb_entry_t rb [2];
   logic      wr_ptr, rd_ptr;
   logic [1:0] cnt;
   logic      started;
   logic      ill_q;
   logic [2:0] dec_f;
   logic      dec_ill;
   logic      accept, push, pop;

   alu_decoder u_dec (
      .aluop   (aluop),
      .funct   (funct),
      .f       (dec_f),
      .illegal (dec_ill)
   );

   // in_ready only looks at registered state, never at handshakes
   always_comb begin
      in_ready = 1'b0;
      nstate   = S_IDLE;
      if (started) begin
         if (state == S_IDLE) in_ready = (cnt != 2'd2);
         else                 in_ready = (cnt == 2'd0);
      end
      accept = in_valid & in_ready;
      if (accept) nstate = S_EXEC;
   end

   assign push      = (state == S_EXEC);
   assign out_valid = (cnt != 2'd0);
   assign pop       = out_valid & out_ready;
   assign result    = rb[rd_ptr].y;
   assign zero      = rb[rd_ptr].z;
   assign illegal   = rb[rd_ptr].ill;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         started <= 1'b0;
      end else begin
         state   <= nstate;
         started <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_a <= '0;
         alu_b <= '0;
         alu_f <= F_AND;
         ill_q <= 1'b0;
      end else if (accept) begin
         alu_a <= srca;
         alu_b <= srcb;
         alu_f <= dec_f;
         ill_q <= dec_ill;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rb[0]    <= '0;
         rb[1]    <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         cnt      <= 2'd0;
         op_count <= 16'd0;
      end else begin
         if (push) begin
            rb[wr_ptr] <= '{y: alu_y, z: alu_zero, ill: ill_q};
            wr_ptr     <= ~wr_ptr;
            op_count   <= op_count + 16'd1;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!reset_n) push |-> (cnt != 2'd2));

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a golden ALU on alu_y/alu_zero.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] srca, srcb;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_f;
   logic [31:0] alu_y;
   logic        alu_zero;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic [15:0] op_count;

   int nvec = 0;
   int nerr = 0;
   int acc;
   int cyc;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aluop     (aluop),
      .funct     (funct),
      .srca      (srca),
      .srcb      (srcb),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_f     (alu_f),
      .alu_y     (alu_y),
      .alu_zero  (alu_zero),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal),
      .op_count  (op_count)
   );

   always_comb begin
      alu_y = 32'd0;
      case (alu_f)
         3'b000:  alu_y = alu_a & alu_b;
         3'b001:  alu_y = alu_a | alu_b;
         3'b010:  alu_y = alu_a + alu_b;
         3'b110:  alu_y = alu_a - alu_b;
         3'b111:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_y = 32'd0;
      endcase
      alu_zero = (alu_y == 32'd0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      aluop    = op;
      funct    = fn;
      srca     = a;
      srcb     = b;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !in_ready; i++) step();
      chk("accept", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      aluop     = 2'b00;
      funct     = 6'd0;
      srca      = 32'd0;
      srcb      = 32'd0;
      step();
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, zero, illegal}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_f", {29'd0, alu_f}, 32'd0);
      chk("rst_op_count", {16'd0, op_count}, 32'd0);
      reset_n = 1'b1;
      chk("rel_in_ready_pre", {31'd0, in_ready}, 32'd0);
      step();
      chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

      // add 5+3 with one-edge latency
      issue(2'b10, 6'b100000, 32'd5, 32'd3);
      chk("s1_alu_f", {29'd0, alu_f}, 32'b010);
      chk("s1_valid_early", {31'd0, out_valid}, 32'd0);
      step();
      chk("s1_valid", {31'd0, out_valid}, 32'd1);
      chk("s1_result", result, 32'd8);
      chk("s1_flags", {30'd0, zero, illegal}, 32'd0);
      chk("s1_op_count", {16'd0, op_count}, 32'd1);
      pop1();
      chk("s1_empty", {31'd0, out_valid}, 32'd0);
      chk("s1_hold_a", alu_a, 32'd5);

      // sub equal operands -> zero
      issue(2'b01, 6'b000000, 32'h1234, 32'h1234);
      chk("s2_alu_f", {29'd0, alu_f}, 32'b110);
      step();
      chk("s2_result", result, 32'd0);
      chk("s2_zero", {31'd0, zero}, 32'd1);
      chk("s2_op_count", {16'd0, op_count}, 32'd2);
      pop1();

      // signed slt and an illegal funct
      issue(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1);
      chk("s3_alu_f_slt", {29'd0, alu_f}, 32'b111);
      step();
      chk("s3_slt", result, 32'd1);
      chk("s3_slt_ill", {31'd0, illegal}, 32'd0);
      pop1();
      issue(2'b11, 6'b111111, 32'hF0, 32'h3C);
      chk("s3_ill_f", {29'd0, alu_f}, 32'b000);
      step();
      chk("s3_ill", {31'd0, illegal}, 32'd1);
      chk("s3_ill_res", result, 32'h30);
      chk("s3_op_count", {16'd0, op_count}, 32'd4);
      pop1();

      // back-pressure: two accepted, third held off
      issue(2'b00, 6'd0, 32'd1, 32'd1);
      issue(2'b00, 6'd0, 32'd3, 32'd4);
      aluop    = 2'b00;
      srca     = 32'd10;
      srcb     = 32'd20;
      in_valid = 1'b1;
      chk("s4_blk0", {31'd0, in_ready}, 32'd0);
      step();
      chk("s4_blk1", {31'd0, in_ready}, 32'd0);
      chk("s4_head_a", result, 32'd2);
      step();
      chk("s4_blk2", {31'd0, in_ready}, 32'd0);
      chk("s4_hold_f", {29'd0, alu_f}, 32'b010);
      out_ready = 1'b1;
      step();
      chk("s4_head_b", result, 32'd7);
      chk("s4_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("s4_drained", {31'd0, out_valid}, 32'd0);
      chk("s4_c_loaded", alu_a, 32'd10);
      step();
      chk("s4_head_c", result, 32'd30);
      chk("s4_op_count", {16'd0, op_count}, 32'd7);
      step();
      out_ready = 1'b0;
      chk("s4_empty", {31'd0, out_valid}, 32'd0);

      // reset during EXEC drops the in-flight op
      issue(2'b00, 6'd0, 32'd7, 32'd8);
      reset_n = 1'b0;
      #1;
      chk("s5_valid", {31'd0, out_valid}, 32'd0);
      chk("s5_op_count", {16'd0, op_count}, 32'd0);
      chk("s5_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("s5_valid_hold", {31'd0, out_valid}, 32'd0);
      reset_n = 1'b1;
      step();
      chk("s5_rel_ready", {31'd0, in_ready}, 32'd1);
      chk("s5_rel_valid", {31'd0, out_valid}, 32'd0);
      chk("s5_rel_count", {16'd0, op_count}, 32'd0);

      // op_count wrap after 65536 pushes
      aluop     = 2'b00;
      srca      = 32'd1;
      srcb      = 32'd1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      acc       = 0;
      cyc       = 0;
      while (acc < 65536 && cyc < 120000) begin
         if (in_ready) acc++;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      chk("s6_budget", acc, 32'd65536);
      chk("s6_ffff", {16'd0, op_count}, 32'hFFFF);
      step();
      chk("s6_wrap", {16'd0, op_count}, 32'd0);
      step();
      step();
      chk("s6_drained", {31'd0, out_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operation valid.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 aluop  input  2  main-decoder ALU op: 00 add, 01 sub, 1x use funct.
REQ-007 funct  input  6  R-type funct field.
REQ-008 srca, srcb  input  32 each  operands.
REQ-009 alu_a, alu_b  output  32 each  registered operands to the downstream combinational ALU.
REQ-010 alu_f  output  3  registered ALU control: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-011 alu_y  input  32  ALU result, combinational from alu_a/alu_b/alu_f.
REQ-012 alu_zero  input  1  ALU zero flag.
REQ-013 out_valid  output  1  result buffer non-empty.
REQ-014 out_ready  input  1  downstream consumes the head entry.
REQ-015 result  output  32  head entry result.
REQ-016 zero  output  1  head entry zero flag.
REQ-017 illegal  output  1  head entry had an undecodable funct.
REQ-018 op_count  output  16  number of results pushed since reset; wraps from FFFF to 0000.

Function
REQ-019 Decode SHALL be: aluop 00 -> 010; 01 -> 110; 1x with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-020 For aluop 1x with any other funct, the block SHALL issue f=000 and tag the entry illegal=1; otherwise illegal=0.
REQ-021 FSM states SHALL be IDLE and EXEC.
REQ-022 IDLE: in_ready=1 iff buffer count < 2; on in_valid & in_ready, register srca, srcb and the decoded f into alu_a/alu_b/alu_f, then go to EXEC.
REQ-023 EXEC: lasts exactly one cycle; at its closing edge push {alu_y, alu_zero, illegal tag} into the buffer and increment op_count.
REQ-024 EXEC: in_ready=1 iff buffer count == 0; an accept in EXEC loads new operands at the same edge as the push and stays in EXEC; otherwise go to IDLE.
REQ-025 in_ready SHALL NOT depend combinationally on out_ready or in_valid.
REQ-026 Latency: an operation accepted at edge N SHALL appear at result with out_valid=1 after edge N+1, assuming the buffer is empty.
REQ-027 Result buffer: 2-entry FIFO; out_valid = count != 0; pop on out_valid & out_ready.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-029 The accept rules SHALL guarantee space at every push; a push into a full buffer SHALL never occur (assertion).
REQ-030 alu_a/alu_b/alu_f SHALL hold their last values when not loading.
REQ-031 in_valid with in_ready=0 SHALL have no effect; upstream holds its inputs.

Reset
REQ-032 While reset_n=0: state IDLE, buffer empty, in_ready=0, out_valid=0, result=0, zero=0, illegal=0, alu_a=alu_b=0, alu_f=000, op_count=0.
REQ-033 Reset asserted mid-EXEC SHALL discard the in-flight operation and all buffered results, with no push.
REQ-034 in_ready SHALL go to 1 on the first clk edge after reset_n deasserts.

Structure
REQ-035 A shared package SHALL hold the aluop codes, funct codes, 3-bit f encodings, and the state enum.
REQ-036 The decode SHALL be one sub-module, alu_decoder (aluop, funct -> f, illegal), and SHALL be purely combinational.
REQ-037 The FIFO SHALL be inline; the ALU itself is external, connected through the alu_* ports.

Verification
REQ-038 The bench SHALL drive alu_y/alu_zero from a golden ALU model.
REQ-039 Scenario 1: aluop=10, funct=100000, srca=5, srcb=3 accepted at edge N -> after edge N+1: out_valid=1, result=8, zero=0, illegal=0, op_count=1.
REQ-040 Scenario 2: aluop=01, srca=srcb=0x1234 -> result=0, zero=1, alu_f=110.
REQ-041 Scenario 3: aluop=10, funct=101010, srca=0xFFFFFFFF, srcb=1 -> result=1; funct=111111 -> illegal=1, alu_f=000.
REQ-042 Scenario 4: out_ready=0 and three operations offered -> two accepted, in_ready=0 afterwards; raising out_ready drains both in order, then the third is accepted.
REQ-043 Scenario 5: reset_n pulsed low during EXEC -> out_valid=0, op_count=0, no result emitted, in_ready=1 one edge after release.
REQ-044 Scenario 6: 65536 operations -> op_count wraps to 0000.
